// File: rtl/uart_buf_pkg.sv
// rtl/uart_buf_pkg.sv - default sizing and shared types for the UART ring buffer
package uart_buf_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int BUF_DEPTH = 16;

    typedef logic [ADDR_W:0] level_t;

endpackage

// File: rtl/uart_buf_ctrl_if.sv
// rtl/uart_buf_ctrl_if.sv - producer/consumer handshakes and RAM ports of the ring buffer
interface uart_buf_ctrl_if
    import uart_buf_pkg::*;
#(
    parameter int WIDTH      = DATA_W,
    parameter int ADDR_WIDTH = ADDR_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [WIDTH-1:0]      mem_wdata;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [WIDTH-1:0]      mem_rdata;

    modport slave (
        input  in_valid, in_data, out_ready, mem_rdata,
        output in_ready, out_valid, out_data,
               mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
    );

    modport master (
        output in_valid, in_data, out_ready, mem_rdata,
        input  in_ready, out_valid, out_data,
               mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
    );

endinterface

// File: rtl/shared_mem.sv
// rtl/shared_mem.sv - simple dual-port RAM with a registered read that holds when idle
module shared_mem #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/uart_buf_ctrl.sv
// rtl/uart_buf_ctrl.sv - ring-buffer sequencer turning shared_mem into a first-word-fall-through FIFO
module uart_buf_ctrl
    import uart_buf_pkg::*;
#(
    parameter int WIDTH      = DATA_W,
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DEPTH      = BUF_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                clr_ovr,
    uart_buf_ctrl_if.slave      bus,
    output logic [ADDR_WIDTH:0] level,
    output logic                full,
    output logic                empty,
    output logic                overrun
);
    localparam int CW = ADDR_WIDTH + 1;

    if (DEPTH != 2**ADDR_WIDTH) begin : g_depth_check
        $error("uart_buf_ctrl: DEPTH must equal 2**ADDR_WIDTH");
    end

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [CW-1:0]         mcount_q, mcount_d;
    logic                  out_valid_q, out_valid_d;
    logic                  overrun_q, overrun_d;
    logic                  push, pop, issue;
    logic [WIDTH-1:0]      wdata;

    assign level   = mcount_q + CW'(out_valid_q);
    assign full    = (level == CW'(DEPTH));
    assign empty   = (level == '0);
    assign overrun = overrun_q;

    assign bus.in_ready = !full && !flush;
    assign push  = bus.in_valid && bus.in_ready;
    assign pop   = out_valid_q && bus.out_ready;
    // mcount excludes this cycle's write, so a read never chases a same-cycle write
    assign issue = (mcount_q != '0) && (!out_valid_q || bus.out_ready) && !flush;

    assign wdata          = bus.in_data;
    assign bus.mem_we     = push;
    assign bus.mem_waddr  = wptr_q;
    assign bus.mem_wdata  = wdata;
    assign bus.mem_re     = issue;
    assign bus.mem_raddr  = rptr_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = bus.mem_rdata;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        mcount_d    = mcount_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;

        if (flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            mcount_d    = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push)  wptr_d = wptr_q + ADDR_WIDTH'(1);
            if (issue) rptr_d = rptr_q + ADDR_WIDTH'(1);
            mcount_d = mcount_q + CW'(push) - CW'(issue);
            if (issue)    out_valid_d = 1'b1;
            else if (pop) out_valid_d = 1'b0;
        end

        // a dropped write outranks a same-cycle clear
        if (clr_ovr) overrun_d = 1'b0;
        if (bus.in_valid && full && !flush) overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            mcount_q    <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            mcount_q    <= mcount_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_uart_buf_ctrl.sv
// tb/tb_uart_buf_ctrl.sv - randomized and directed bench for uart_buf_ctrl with shared_mem
module tb_uart_buf_ctrl;
    import uart_buf_pkg::*;

    logic   clk     = 1'b0;
    logic   rst     = 1'b1;
    logic   flush   = 1'b0;
    logic   clr_ovr = 1'b0;
    level_t level;
    logic   full, empty, overrun;

    uart_buf_ctrl_if #(.WIDTH(DATA_W), .ADDR_WIDTH(ADDR_W)) bus ();

    uart_buf_ctrl #(.WIDTH(DATA_W), .ADDR_WIDTH(ADDR_W), .DEPTH(BUF_DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .clr_ovr (clr_ovr),
        .bus     (bus),
        .level   (level),
        .full    (full),
        .empty   (empty),
        .overrun (overrun)
    );

    shared_mem #(.WIDTH(DATA_W), .ADDR_WIDTH(ADDR_W)) mem (
        .clk   (clk),
        .we    (bus.mem_we),
        .waddr (bus.mem_waddr),
        .wdata (bus.mem_wdata),
        .re    (bus.mem_re),
        .raddr (bus.mem_raddr),
        .rdata (bus.mem_rdata)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference: the buffer is a queue of held words; the head is "presented" once fetched.
    logic [7:0] held[$];
    bit         pres;
    int         wp, rp, cyc;
    bit         ovr;
    int         n;
    bit         e_full, e_rdy, e_push, e_pop, e_issue;
    logic [7:0] pop_q[$];
    int         pop_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            held.delete();
            pres = 0; wp = 0; rp = 0; ovr = 0;
        end else begin
            n       = held.size();
            e_full  = (n == BUF_DEPTH);
            e_rdy   = !e_full && !flush;
            e_push  = bus.in_valid && e_rdy;
            e_pop   = pres && bus.out_ready;
            e_issue = ((n - int'(pres)) > 0) && (!pres || bus.out_ready) && !flush;

            chk("level", 32'(level), 32'(n));
            chk("full", 32'(full), 32'(e_full));
            chk("empty", 32'(empty), 32'(n == 0));
            chk("in_ready", 32'(bus.in_ready), 32'(e_rdy));
            chk("overrun", 32'(overrun), 32'(ovr));
            chk("out_valid", 32'(bus.out_valid), 32'(pres));
            chk("mem_we", 32'(bus.mem_we), 32'(e_push));
            chk("mem_re", 32'(bus.mem_re), 32'(e_issue));
            if (pres)    chk("out_data", 32'(bus.out_data), 32'(held[0]));
            if (e_push)  chk("mem_waddr", 32'(bus.mem_waddr), 32'(wp));
            if (e_issue) chk("mem_raddr", 32'(bus.mem_raddr), 32'(rp));
            if (e_pop) begin
                pop_q.push_back(bus.out_data);
                pop_cyc.push_back(cyc);
            end

            if (bus.in_valid && e_full && !flush) ovr = 1;
            else if (clr_ovr)                     ovr = 0;

            if (flush) begin
                held.delete();
                pres = 0; wp = 0; rp = 0;
            end else begin
                if (e_pop)   void'(held.pop_front());
                if (e_push)  held.push_back(bus.in_data);
                if (e_push)  wp = (wp + 1) % BUF_DEPTH;
                if (e_issue) rp = (rp + 1) % BUF_DEPTH;
                pres = e_issue ? 1'b1 : (e_pop ? 1'b0 : pres);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    int c0;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        step(); step();
        rst = 1'b0;

        mid();
        chk("idle_empty", 32'(empty), 32'd1);
        chk("idle_level", 32'(level), 32'd0);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_mem_we", 32'(bus.mem_we), 32'd0);
        chk("idle_mem_re", 32'(bus.mem_re), 32'd0);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        step();

        // single word latency
        bus.in_valid = 1'b1; bus.in_data = 8'hA5;
        mid(); chk("a5_we", 32'(bus.mem_we), 32'd1); chk("a5_waddr", 32'(bus.mem_waddr), 32'd0);
        step();
        bus.in_valid = 1'b0;
        mid(); chk("a5_re", 32'(bus.mem_re), 32'd1); chk("a5_raddr", 32'(bus.mem_raddr), 32'd0);
        chk("a5_ov_c1", 32'(bus.out_valid), 32'd0);
        step();
        mid(); chk("a5_ov_c2", 32'(bus.out_valid), 32'd1); chk("a5_data_c2", 32'(bus.out_data), 32'hA5);
        step();
        mid(); chk("a5_ov_c3", 32'(bus.out_valid), 32'd1); chk("a5_data_c3", 32'(bus.out_data), 32'hA5);
        step();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        mid(); chk("a5_empty", 32'(empty), 32'd1);
        step();

        // fill to capacity, then overrun
        pop_q.delete();
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'(i);
            step();
        end
        bus.in_data = 8'hFF;
        mid();
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_level", 32'(level), 32'd16);
        chk("ovr_we", 32'(bus.mem_we), 32'd0);
        chk("ovr_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        bus.in_valid = 1'b0;
        mid(); chk("ovr_set", 32'(overrun), 32'd1);
        step();
        clr_ovr = 1'b1; bus.in_valid = 1'b1;
        step();
        clr_ovr = 1'b0; bus.in_valid = 1'b0;
        mid(); chk("ovr_set_wins", 32'(overrun), 32'd1);
        step();
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        mid(); chk("ovr_cleared", 32'(overrun), 32'd0);
        step();
        bus.out_ready = 1'b1;
        repeat (20) step();
        bus.out_ready = 1'b0;
        chk("fill_pop_count", 32'(pop_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < pop_q.size(); i++)
            chk("fill_pop_data", 32'(pop_q[i]), 32'(i));

        // streaming with pointer wrap
        pop_q.delete(); pop_cyc.delete();
        bus.out_ready = 1'b1;
        c0 = cyc + 1;
        for (int i = 0; i < 40; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'(8'h40 + i);
            step();
        end
        bus.in_valid = 1'b0;
        repeat (5) step();
        chk("stream_count", 32'(pop_q.size()), 32'd40);
        if (pop_cyc.size() > 0) chk("stream_latency", 32'(pop_cyc[0] - c0), 32'd2);
        for (int i = 0; i < 40 && i < pop_q.size(); i++) begin
            chk("stream_data", 32'(pop_q[i]), 32'(8'h40 + i));
            chk("stream_gap", 32'(pop_cyc[i] - pop_cyc[0]), 32'(i));
        end

        // flush mid-stream
        bus.out_ready = 1'b0;
        pop_q.delete();
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'(8'h80 + i);
            step();
        end
        bus.in_valid = 1'b0;
        repeat (3) step();
        mid(); chk("flush_pre_level", 32'(level), 32'd5);
        step();
        flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hEE;
        mid();
        chk("flush_we", 32'(bus.mem_we), 32'd0);
        chk("flush_re", 32'(bus.mem_re), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        flush = 1'b0; bus.in_valid = 1'b0;
        mid(); chk("flush_level", 32'(level), 32'd0); chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        step();
        bus.in_valid = 1'b1; bus.in_data = 8'h5A;
        mid(); chk("post_flush_we", 32'(bus.mem_we), 32'd1); chk("post_flush_waddr", 32'(bus.mem_waddr), 32'd0);
        step();
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (4) step();
        chk("post_flush_count", 32'(pop_q.size()), 32'd1);
        if (pop_q.size() > 0) chk("post_flush_data", 32'(pop_q[0]), 32'h5A);

        // randomized traffic against the reference queue
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 4) < ((i / 500) % 2 == 0 ? 1 : 4));
            flush         = ($urandom_range(0, 63) == 0);
            clr_ovr       = ($urandom_range(0, 31) == 0);
            step();
        end
        bus.in_valid = 1'b0; flush = 1'b0; clr_ovr = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/uart_buf_ctrl.md
# uart_buf_ctrl

Ring-buffer controller that sequences the `shared_mem` dual-port RAM between one producer (UART RX byte path) and one consumer (UART TX byte path). It owns the write/read pointers, occupancy count, full/empty and overrun status. It drives the RAM's write and read ports so the RAM behaves as a first-word-fall-through FIFO with valid/ready handshakes on both sides. `shared_mem` is instantiated beside this block, not inside it.

## Interface
Parameters:
- `WIDTH`, 8, data width; must match `shared_mem`.
- `ADDR_WIDTH`, 4, RAM address width.
- `DEPTH`, 16, entry count; must equal 2**ADDR_WIDTH.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous buffer clear; not a reset.
- `clr_ovr` in 1: clears the sticky overrun flag.
- `in_valid` in 1, `in_ready` out 1, `in_data` in WIDTH: producer handshake.
- `out_valid` out 1, `out_ready` in 1, `out_data` out WIDTH: consumer handshake.
- `level` out ADDR_WIDTH+1: entries held, including any presented on `out_data`.
- `full` out 1, `empty` out 1, `overrun` out 1: status.
- `mem_we` out 1, `mem_waddr` out ADDR_WIDTH, `mem_wdata` out WIDTH: RAM write port.
- `mem_re` out 1, `mem_raddr` out ADDR_WIDTH, `mem_rdata` in WIDTH: RAM read port (1-cycle registered read; holds its value when `mem_re`=0).

## Operation
- State: `wptr`, `rptr` (ADDR_WIDTH, wrap naturally at DEPTH-1→0), `mcount` (ADDR_WIDTH+1, entries in RAM not yet read-issued), `out_valid` register, `overrun` register.
- `level` = `mcount` + `out_valid`. `full` = (`level` == DEPTH). `empty` = (`level` == 0).
- `in_ready` = !`full` && !`flush`. Push when `in_valid` && `in_ready`:
  - `mem_we`=1, `mem_waddr`=`wptr`, `mem_wdata`=`in_data` (combinational).
  - `wptr` increments.
- Pop = `out_valid` && `out_ready`.
- Issue = (`mcount` != 0) && (!`out_valid` || `out_ready`) && !`flush`. On issue:
  - `mem_re`=1, `mem_raddr`=`rptr`.
  - `rptr` increments.
  - `out_valid` is set next cycle.
- `out_valid` next value: 1 if issue; else 0 if pop; else hold.
- `out_data` = `mem_rdata`, wired directly. It is stable while `out_valid`=1 and not popped, because no read is issued then.
- `mcount` next value = `mcount` + push − issue. Simultaneous push and issue leaves it unchanged.
- Same-address hazard: an entry written in cycle N is counted in `mcount` only from N+1. A read never targets an entry being written in the same cycle.
- Overrun: `in_valid` && `full` && !`flush` sets `overrun`. The data is dropped and `mem_we` stays 0. `clr_ovr` clears `overrun`; a set and a clear in the same cycle resolve to set.
- Flush: next cycle `wptr`=`rptr`=0, `mcount`=0, `out_valid`=0. During the flush cycle, `mem_we`=`mem_re`=0 and `in_ready`=0. `overrun` is unaffected.
- Priority: `rst` > `flush` > normal operation.

## Timing
- Reset values: `wptr`=`rptr`=0, `mcount`=0, `out_valid`=0, `overrun`=0. Therefore `empty`=1, `full`=0, `level`=0, `in_ready`=1 (unless `flush`). `mem_we`/`mem_re` follow their equations and are 0 with no stimulus.
- Latency into an empty buffer: push at cycle N → read issued at N+1 → `out_valid`=1 with data at N+2.
- Throughput: 1 push and 1 pop per cycle sustained, with no bubbles once `out_valid`=1.
- `in_ready` depends on registered state and `flush` only; it has no combinational path from `in_valid`.
- `rst` or `flush` asserted mid-stream discards all held data, including the word on `out_data`.

## Structure
- Package `uart_buf_pkg`: default `WIDTH`/`ADDR_WIDTH`/`DEPTH` constants and a `level_t` typedef of width ADDR_WIDTH+1.
- Single module; no sub-module needed.
- An elaboration-time check enforces DEPTH == 2**ADDR_WIDTH.
- The bench instantiates `uart_buf_ctrl` together with `shared_mem`.

## Test plan
- Reset, then idle → `empty`=1, `level`=0, `out_valid`=0, `mem_we`=`mem_re`=0, `in_ready`=1.
- Push 0xA5 at cycle 0 with `out_ready`=0 → `mem_re` at cycle 1 with `mem_raddr`=0; `out_valid`=1 and `out_data`=0xA5 from cycle 2, held until `out_ready`=1.
- Push 16 bytes 0x00..0x0F with `out_ready`=0 → `full`=1 and `level`=16 after the last push. A 17th push (0xFF) → `overrun`=1, `mem_we`=0, and subsequent pops return 0x00..0x0F only.
- Continuous push/pop of 40 bytes with `out_ready`=1 → output order is exact, one word per cycle after the 2-cycle fill, and both pointers wrap past 15 twice.
- Hold `level`=5, then assert `flush` for one cycle with `in_valid`=1 → that word is dropped, and next cycle `level`=0, `out_valid`=0. The next push lands at address 0.
- Assert `clr_ovr` and a full-buffer push in the same cycle → `overrun` stays 1. `clr_ovr` alone → 0.
